// File: rtl/bit_interleaver.sv
`default_nettype none
// ============================================================================
// Module      : bit_interleaver
// Description : Row/column block interleaver for the coded dibit stream
//               between the convolutional encoder and the QPSK modulator.
//               Entries are written row-major into one bank of a ping-pong
//               store and read column-major from the other bank. Both sides
//               advance on the same strobe, so rates always match.
//
// Ports       : CLOCK_50      - system clock, all state on rising edge
//               reset_n       - asynchronous active-low reset
//               in_valid      - one-cycle strobe, in_data accepted
//               in_data       - encoder output entry (W bits)
//               bypass_req    - pass-through request, sampled at frame end
//               out_valid     - registered, one cycle after accepted strobe
//               out_data      - interleaved (or bypassed) entry
//               out_sof       - first entry of each output frame
//               bypass_active - current frame runs in pass-through mode
//
// Revision    : 1.0 - initial release
// ============================================================================
module bit_interleaver #(
    parameter int ROWS = 4,
    parameter int COLS = 8,
    parameter int W    = 2
) (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         bypass_req,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_sof,
    output logic         bypass_active
);

    localparam int c_N  = ROWS * COLS;
    localparam int c_AW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(ROWS - 1);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(COLS - 1);
    localparam logic [c_AW-1:0] c_COLS_A   = c_AW'(COLS);

    // Ping-pong storage; contents are never reset because every location
    // is written before the bank is swapped onto the read side.
    logic [W-1:0]    r_bank0 [c_N];
    logic [W-1:0]    r_bank1 [c_N];

    logic [c_RW-1:0] r_wr;
    logic [c_CW-1:0] r_wc;
    logic [c_RW-1:0] r_rr;
    logic [c_CW-1:0] r_rc;
    logic            r_wbank;
    logic            r_primed;
    logic            r_bypass;
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic            r_out_sof;

    logic [c_AW-1:0] w_waddr;
    logic [c_AW-1:0] w_raddr;
    logic [W-1:0]    w_rdata;
    logic            w_wc_last;
    logic            w_rr_last;
    logic            w_boundary;

    assign w_waddr    = c_AW'(r_wr) * c_COLS_A + c_AW'(r_wc);
    assign w_raddr    = c_AW'(r_rr) * c_COLS_A + c_AW'(r_rc);
    assign w_rdata    = r_wbank ? r_bank0[w_raddr] : r_bank1[w_raddr];
    assign w_wc_last  = (r_wc == c_COL_LAST);
    assign w_rr_last  = (r_rr == c_ROW_LAST);
    // Write and read sides step together, so the write side alone marks
    // the end of a frame; the read counters are at their last entry too.
    assign w_boundary = w_wc_last && (r_wr == c_ROW_LAST);

    // Storage write port (no reset on the memory itself).
    always_ff @(posedge CLOCK_50) begin
        if (in_valid) begin
            if (r_wbank) begin
                r_bank1[w_waddr] <= in_data;
            end else begin
                r_bank0[w_waddr] <= in_data;
            end
        end
    end

    // Counters, bank select, mode and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_wr        <= '0;
            r_wc        <= '0;
            r_rr        <= '0;
            r_rc        <= '0;
            r_wbank     <= 1'b0;
            r_primed    <= 1'b0;
            r_bypass    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sof   <= 1'b0;
        end else if (in_valid) begin
            // Output uses the mode and read position in force for this
            // strobe; the boundary strobe still reads the outgoing bank.
            r_out_valid <= r_primed || r_bypass;
            if (r_bypass) begin
                r_out_data <= in_data;
                r_out_sof  <= (r_wr == '0) && (r_wc == '0);
            end else if (r_primed) begin
                r_out_data <= w_rdata;
                r_out_sof  <= (r_rr == '0) && (r_rc == '0);
            end else begin
                r_out_sof  <= 1'b0;
            end

            if (w_boundary) begin
                r_wr     <= '0;
                r_wc     <= '0;
                r_rr     <= '0;
                r_rc     <= '0;
                r_wbank  <= ~r_wbank;
                r_primed <= 1'b1;
                r_bypass <= bypass_req;
            end else begin
                // Write side: column first, row on column wrap.
                if (w_wc_last) begin
                    r_wc <= '0;
                    r_wr <= r_wr + 1'b1;
                end else begin
                    r_wc <= r_wc + 1'b1;
                end
                // Read side: row first, column on row wrap.
                if (w_rr_last) begin
                    r_rr <= '0;
                    r_rc <= r_rc + 1'b1;
                end else begin
                    r_rr <= r_rr + 1'b1;
                end
            end
        end else begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_sof       = r_out_sof;
    assign bypass_active = r_bypass;

endmodule
`default_nettype wire

// File: doc/bit_interleaver.md
# bit_interleaver

Row/column block interleaver on the coded dibit stream: it sits between the convolutional encoder and the QPSK modulator. It spreads the Gilbert-channel error bursts across many trellis steps so the Viterbi decoder sees isolated errors. Dibits are written row-major into one bank of a ping-pong store and read column-major from the other bank at the same strobe rate. A matching de-interleaver is built separately on the receive side.

## Interface
- ROWS, 4, interleaver rows (depth of spreading); ≥2
- COLS, 8, interleaver columns; ≥2; frame size N = ROWS*COLS entries
- W, 2, entry width in bits (2 = one encoder dibit {g1,g0})
- CLOCK_50  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  one-cycle strobe: in_data is accepted this cycle
- in_data  in  W  encoder output entry
- bypass_req  in  1  request pass-through mode; sampled only at frame boundaries
- out_valid  out  W?1:1  registered; high one cycle after each accepted strobe once primed
- out_data  out  W  interleaved entry, valid while out_valid
- out_sof  out  1  high with out_valid on the first entry of each output frame
- bypass_active  out  1  current frame is running in pass-through mode

## Operation
- Storage: two banks of N×W bits (bank 0, bank 1); wbank selects the write bank, and the read bank is ~wbank.
- Write counters wr (0..ROWS-1) and wc (0..COLS-1). Per accepted strobe, write address = wr*COLS+wc. wc increments first; on wc wrap, wr increments.
- Read counters rr (0..ROWS-1) and rc (0..COLS-1). Per accepted strobe, read address = rr*COLS+rc. rr increments first; on rr wrap, rc increments.
- Write and read advance on the same strobe, so rates always match. No full/empty/overflow condition can exist.
- The frame boundary is the strobe that writes entry N-1 (wr=ROWS-1, wc=COLS-1). On that strobe:
  - all four counters return to 0;
  - wbank toggles;
  - primed is set to 1;
  - bypass_active is loaded from bypass_req.
- primed=0 after reset: writes proceed, out_valid stays 0.
- primed=1, bypass_active=0: on each strobe, out_data ← read bank[rr*COLS+rc].
- bypass_active=1: on each strobe, out_data ← in_data. Out_valid is driven even when unprimed. Counters and writes still run, so leaving bypass at the next boundary yields a valid interleaved frame.
- out_sof = 1 with the output produced on the strobe where rr=0 and rc=0 (interleaved) or wr=0 and wc=0 (bypass).
- in_valid low: no counter, bank, or output-data change. Out_valid and out_sof drop to 0 the next cycle.
- bypass_req changing mid-frame has no effect until the next boundary.

## Timing
- Reset (async assert, sync-safe deassert) sets:
  - out_valid=0, out_sof=0, out_data=0, bypass_active=0;
  - primed=0, wbank=0, all counters 0.
- Bank contents are not reset. They are never read before being written.
- Output latency is one CLOCK_50 cycle from an accepted strobe to out_valid.
- End-to-end delay (interleaved) is N strobes + 1 cycle: entry k of frame f appears during frame f+1.
- Back-to-back strobes on consecutive cycles are supported, giving one output per cycle.
- The boundary strobe itself reads the last column-major entry of the outgoing read bank before the swap takes effect.
- Reset asserted mid-frame discards the partial frame. The first output after release requires N fresh strobes.

## Test plan
- Fill/order: W=8, ROWS=4, COLS=8; strobes every cycle with data 0..63.
  - No out_valid for the first 32 strobes.
  - Then outputs 0,8,16,24,1,9,17,25,…,7,15,23,31 in order.
  - out_sof is high only with the value 0.
- Ping-pong continuity: continue with data 64..95. The second frame outputs 32,40,48,56,33,…,63 with no gap, and out_sof is high with 32.
- Gapped strobes: same as the fill/order test, but in_valid is high only every 5th cycle. The output sequence is identical, with out_valid exactly one cycle after each strobe.
- Bypass switching:
  - Assert bypass_req at strobe 10 of frame 0. Output stays silent until the boundary.
  - Frame 1 outputs its own inputs directly (32,33,…), with bypass_active=1 from the boundary.
  - Drop bypass_req during frame 1. Frame 2 outputs frame 1 interleaved (32,40,…).
- Reset mid-frame: apply reset_n=0 after 20 strobes of frame 1.
  - All outputs drop to 0 asynchronously.
  - After release, feed 100..131. No output appears until those 32 strobes complete, then 100,108,116,124,… follows.
- W=2 default: feed the encoder-pattern dibits 3,0,1,2 repeating for 64 strobes. The second-frame output equals the column-major reorder of that pattern; check against the address formula.
